// File: rtl/irq_pend_ctrl_if.sv
// Request/issue bundle between the interrupt sources, the external
// 16-to-4 priority encoder, the consumer, and irq_pend_ctrl.
interface irq_pend_ctrl_if;
  logic [15:0] req_in;
  logic [15:0] mask_in;
  logic [15:0] enc_vec;
  logic        enc_en;
  logic [3:0]  enc_idx;
  logic        out_valid;
  logic [3:0]  out_id;
  logic        out_ready;
  logic [4:0]  pend_cnt;
  logic        ovf_flag;

  modport master (
    output req_in,
    output mask_in,
    output enc_idx,
    output out_ready,
    input  enc_vec,
    input  enc_en,
    input  out_valid,
    input  out_id,
    input  pend_cnt,
    input  ovf_flag
  );

  modport slave (
    input  req_in,
    input  mask_in,
    input  enc_idx,
    input  out_ready,
    output enc_vec,
    output enc_en,
    output out_valid,
    output out_id,
    output pend_cnt,
    output ovf_flag
  );
endinterface

// File: rtl/irq_pend_ctrl.sv
// Interrupt pending register with one-at-a-time issue via an external encoder.
// Define IRQ_EDGE_DETECT_EN for rising-edge capture; default is level capture.
module irq_pend_ctrl (
  input  logic clk,
  input  logic rst_n,
  irq_pend_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pend;
  logic [15:0] set_v;
  logic [15:0] clr_v;
  logic [15:0] hit;
  logic [3:0]  id_q;
  logic        ovf_q;
  logic        valid;
  logic [4:0]  cnt;

`ifdef IRQ_EDGE_DETECT_EN
  logic [15:0] req_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev <= '0;
    end else begin
      req_prev <= bus.req_in;
    end
  end

  assign set_v = bus.req_in & ~req_prev;
`else
  assign set_v = bus.req_in;
`endif

  always_comb begin
    clr_v = '0;
    if (state == ISSUE && bus.out_ready) begin
      clr_v[id_q] = 1'b1;
    end
  end

  // a set landing on the clearing edge keeps the bit and is not an overflow
  assign hit = set_v & pend & ~clr_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_v) | set_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (|hit) begin
      ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.enc_en) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    unique case (state)
      IDLE:    valid = 1'b0;
      ISSUE:   valid = 1'b1;
      default: valid = 1'b0;
    endcase
  end

  // id is captured only on entry, so it is frozen for the whole issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q <= '0;
    end else if (state == IDLE && bus.enc_en) begin
      id_q <= bus.enc_idx;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'b0, pend[i]};
    end
  end

  assign bus.enc_vec   = pend & bus.mask_in;
  assign bus.enc_en    = |bus.enc_vec;
  assign bus.out_valid = valid;
  assign bus.out_id    = id_q;
  assign bus.pend_cnt  = cnt;
  assign bus.ovf_flag  = ovf_q;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// Self-checking bench for irq_pend_ctrl: per-source model plus directed vectors.
module tb_irq_pend_ctrl;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   issues;
  logic count_on;
  logic prev_valid;

  irq_pend_ctrl_if bus ();

  irq_pend_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] lowest(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // environment's priority encoder
  assign bus.enc_idx = lowest(bus.enc_vec);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: one pending flag per source, one "busy with id" slot
  logic [15:0] m_pend;
  logic [15:0] m_prev;
  logic        m_busy;
  logic [3:0]  m_id;
  logic        m_ovf;

  always @(posedge clk or negedge rst_n) begin : mdl
    logic [15:0] np;
    logic        fire;
    logic        done;
    logic        ovf;
    if (!rst_n) begin
      m_pend <= '0;
      m_prev <= '0;
      m_busy <= 1'b0;
      m_id   <= '0;
      m_ovf  <= 1'b0;
    end else begin
      np  = m_pend;
      ovf = m_ovf;
      for (int i = 0; i < 16; i++) begin
`ifdef IRQ_EDGE_DETECT_EN
        fire = bus.req_in[i] && !m_prev[i];
`else
        fire = bus.req_in[i];
`endif
        done = m_busy && bus.out_ready && (int'(m_id) == i);
        if (fire && m_pend[i] && !done) ovf = 1'b1;
        if (fire) np[i] = 1'b1;
        else if (done) np[i] = 1'b0;
      end
      if (m_busy) begin
        if (bus.out_ready) m_busy <= 1'b0;
      end else if ((m_pend & bus.mask_in) != 16'h0) begin
        m_busy <= 1'b1;
        m_id   <= lowest(m_pend & bus.mask_in);
      end
      m_pend <= np;
      m_ovf  <= ovf;
      m_prev <= bus.req_in;
    end
  end

  always @(negedge clk) begin
    chk("valid", int'(bus.out_valid), int'(m_busy));
    if (m_busy) chk("id", int'(bus.out_id), int'(m_id));
    chk("cnt", int'(bus.pend_cnt), $countones(m_pend));
    chk("ovf", int'(bus.ovf_flag), int'(m_ovf));
    chk("enc_vec", int'(bus.enc_vec), int'(m_pend & bus.mask_in));
    chk("enc_en", int'(bus.enc_en), int'((m_pend & bus.mask_in) != 0));
    if (count_on && bus.out_valid && !prev_valid) issues++;
    prev_valid <= bus.out_valid;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    issues     = 0;
    count_on   = 1'b0;
    prev_valid = 1'b0;
    rst_n         = 1'b0;
    bus.req_in    = 16'h0;
    bus.mask_in   = 16'hFFFF;
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_cnt", int'(bus.pend_cnt), 0);
    chk("rst_id", int'(bus.out_id), 0);
    rst_n = 1'b1;
    cyc();

    // single pulse on source 0
    bus.req_in = 16'h0001;
    bus.out_ready = 1'b1;
    cyc();
    bus.req_in = 16'h0;
    chk("p0_cnt1", int'(bus.pend_cnt), 1);
    chk("p0_idle", int'(bus.out_valid), 0);
    cyc();
    chk("p0_valid", int'(bus.out_valid), 1);
    chk("p0_id", int'(bus.out_id), 0);
    cyc();
    chk("p0_drop", int'(bus.out_valid), 0);
    chk("p0_cnt0", int'(bus.pend_cnt), 0);

    // two sources, lowest first, two cycles apart
    bus.req_in = 16'h8010;
    cyc();
    bus.req_in = 16'h0;
    chk("two_cnt", int'(bus.pend_cnt), 2);
    cyc();
    chk("two_id4", int'(bus.out_id), 4);
    cyc();
    chk("two_gap", int'(bus.out_valid), 0);
    cyc();
    chk("two_id15", int'(bus.out_id), 15);
    cyc();
    chk("two_ovf", int'(bus.ovf_flag), 0);
    chk("two_cnt0", int'(bus.pend_cnt), 0);

    // masked bit stays pending, issues when unmasked
    bus.mask_in = 16'hFFFB;
    bus.req_in  = 16'h0004;
    cyc();
    bus.req_in = 16'h0;
    cyc();
    cyc();
    chk("msk_en", int'(bus.enc_en), 0);
    chk("msk_valid", int'(bus.out_valid), 0);
    chk("msk_cnt", int'(bus.pend_cnt), 1);
    bus.mask_in = 16'hFFFF;
    cyc();
    chk("msk_id2", int'(bus.out_id), 2);
    chk("msk_valid2", int'(bus.out_valid), 1);
    cyc();

    // stalled issue, id hold, overflow, set-wins-over-clear
    bus.out_ready = 1'b0;
    bus.req_in = 16'h0008;
    cyc();
    bus.req_in = 16'h0;
    cyc();
    chk("st_id3", int'(bus.out_id), 3);
    bus.req_in  = 16'h0008;
    bus.mask_in = 16'h0;
    cyc();
    bus.req_in = 16'h0;
    chk("st_hold", int'(bus.out_id), 3);
    chk("st_ovf", int'(bus.ovf_flag), 1);
    cyc();
    bus.out_ready = 1'b1;
    bus.req_in = 16'h0008;
    cyc();
    bus.req_in = 16'h0;
    chk("sw_valid", int'(bus.out_valid), 0);
    chk("sw_cnt", int'(bus.pend_cnt), 1);
    bus.mask_in = 16'hFFFF;
    cyc();
    cyc();
    chk("sw_clr", int'(bus.pend_cnt), 0);

    // asynchronous reset mid-issue
    bus.out_ready = 1'b0;
    bus.req_in = 16'h0020;
    cyc();
    bus.req_in = 16'h0;
    cyc();
    chk("ar_pre", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(bus.out_valid), 0);
    chk("ar_cnt", int'(bus.pend_cnt), 0);
    chk("ar_ovf", int'(bus.ovf_flag), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // held-high line
    bus.out_ready = 1'b1;
    count_on = 1'b1;
    bus.req_in = 16'h0080;
    repeat (6) cyc();
    bus.req_in = 16'h0;
    repeat (4) cyc();
    count_on = 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
    chk("held_issues", issues, 1);
`else
    chk("held_issues", issues, 3);
`endif
    chk("held_cnt", int'(bus.pend_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_pend_ctrl.md
IRQ_PEND_CTRL -- requirements
Module: irq_pend_ctrl

Interface
REQ-001 The block SHALL have no parameters; the request width is fixed at 16 and the index width at 4, matching the 16-to-4 priority encoder it drives.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_in  input  16  raw request lines, one per source.
REQ-005 mask_in  input  16  per-source enable; 1 = eligible for issue.
REQ-006 enc_vec  output  16  combinational pend & mask_in, driven to the encoder's bin_in.
REQ-007 enc_en  output  1  combinational OR-reduce of enc_vec, driven to the encoder's en.
REQ-008 enc_idx  input  4  encoder result; lowest set index of enc_vec wins.
REQ-009 out_valid  output  1  an issued source index is presented.
REQ-010 out_id  output  4  issued source index.
REQ-011 out_ready  input  1  consumer accepts out_id when high with out_valid.
REQ-012 pend_cnt  output  5  population count of the pending register, 0..16, masked bits included.
REQ-013 ovf_flag  output  1  sticky; set when a request hits an already-pending bit.

Function
REQ-014 The block SHALL hold a 16-bit pending register pend; source i sets pend[i] per REQ-030/031.
REQ-015 The FSM SHALL have two states: IDLE and ISSUE.
REQ-016 In IDLE with enc_en=1 at an edge, the FSM SHALL register out_id <= enc_idx and enter ISSUE.
REQ-017 In IDLE with enc_en=0, the FSM SHALL remain in IDLE.
REQ-018 In ISSUE, out_valid SHALL be 1; in IDLE, out_valid SHALL be 0.
REQ-019 out_id SHALL be stable for the whole ISSUE state regardless of mask_in, req_in or enc_idx changes.
REQ-020 In ISSUE with out_ready=1 at an edge, pend[out_id] SHALL clear and the FSM SHALL return to IDLE.
REQ-021 In ISSUE with out_ready=0, the state and pend[out_id] SHALL hold.
REQ-022 If a set of pend[out_id] and its handshake clear occur on the same edge, the set SHALL win and the bit SHALL remain pending.
REQ-023 Latency SHALL be one edge from pend set to the FSM entering ISSUE, for an unmasked source with the FSM idle; maximum throughput SHALL be one issue per two cycles.
REQ-024 Masking a bit SHALL NOT clear it; it SHALL become eligible again when unmasked.
REQ-025 ovf_flag SHALL set when a source's set condition is true while its pend bit is already 1, except on the edge where that bit is being cleared by handshake.
REQ-026 pend_cnt SHALL reflect the registered pend, updated one edge after the set or clear.

Reset
REQ-027 While rst_n=0: pend=0, FSM=IDLE, out_valid=0, out_id=0, ovf_flag=0, pend_cnt=0, and the edge-detect history=0.
REQ-028 Reset SHALL take effect immediately and asynchronously, including mid-ISSUE; the pending issue SHALL be discarded without a handshake.
REQ-029 Release of rst_n SHALL be sampled on a clock edge; the first update SHALL occur on the first edge with rst_n=1.

Configuration
REQ-030 With IRQ_EDGE_DETECT_EN defined: pend[i] SHALL set only on an edge where req_in[i]=1 and the registered previous req_in[i]=0; a held-high line SHALL issue once.
REQ-031 Without IRQ_EDGE_DETECT_EN: pend[i] SHALL set on every edge where req_in[i]=1 (level mode), the history register SHALL be absent, and a held-high line SHALL re-issue after each clear.

Verification
REQ-032 After reset, pulse req_in=0x0001 for one cycle with mask_in=0xFFFF: out_valid=1 with out_id=0 after the second edge; hold out_ready=1: pend_cnt goes 0->1->0 and out_valid drops.
REQ-033 Set req_in=0x8010 for one cycle with out_ready=1: issues out_id=4 then out_id=15, two cycles apart; ovf_flag stays 0.
REQ-034 Set pend 0x0004 and mask_in=0xFFFB: enc_en=0, out_valid stays 0 and pend_cnt=1; then set mask_in=0xFFFF: out_id=2 is issued.
REQ-035 Enter ISSUE with out_id=3 and out_ready=0, then pulse req_in[3] and change mask_in to 0: out_id holds 3 and ovf_flag=1; on out_ready=1 with a concurrent req_in[3] edge, pend[3] remains set.
REQ-036 Assert rst_n=0 asynchronously mid-ISSUE: out_valid, pend_cnt and ovf_flag go to 0 before the next edge. Hold req_in[7]=1 for 6 cycles with out_ready=1: one issue with IRQ_EDGE_DETECT_EN, three issues without.
